pdm_recorder: RTL

Capture side of the audio path. Drives the on-board PDM microphone clock, decimates the 1-bit PDM stream into 8-bit unsigned PCM samples, and writes them sequentially into the shared sample memory through a simple write port. The playback PWM player later reads that memory from address 0 upward. It uses the same 8-bit sample format and 20-bit address space as the player.

---
 rtl/audio_pkg.sv | 20 ++
 rtl/pdm_decimator.sv | 79 +++++++
 rtl/pdm_recorder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: sample format, address space and recorder state encoding shared
// by the PDM recorder and the PWM player.
package audio_pkg;

  localparam int unsigned SAMPLE_W      = 8;
  localparam int unsigned ADDR_W        = 20;
  localparam int unsigned DEFAULT_DEPTH = 262144;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    DONE   = 2'd2
  } rec_state_t;

  // Clamp a scaled ones count (0..256) into the 8-bit unsigned sample range.
  function automatic logic [SAMPLE_W-1:0] sat_sample(input logic [8:0] v);
    return v[8] ? {SAMPLE_W{1'b1}} : v[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/pdm_decimator.sv
// pdm_decimator: generates the microphone clock, samples the PDM bit once per
// mic_clk period and box-car decimates DECIM bits into one 8-bit PCM sample.
// Ports:
//   clk_i, rst_i     system clock, synchronous active-high reset
//   clear_i          restart the current window (bit counter and accumulator)
//   mic_data_i       PDM data from the microphone
//   mic_clk_o        PDM clock to the microphone
//   sample_c         scaled sample of the window ending this cycle
//   sample_valid_c   high on the cycle of the window's final bit strobe
module pdm_decimator
  import audio_pkg::*;
#(
  parameter int unsigned CLK_DIV_HALF = 20,
  parameter int unsigned DECIM        = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                mic_data_i,
  output logic                mic_clk_o,
  output logic [SAMPLE_W-1:0] sample_c,
  output logic                sample_valid_c
);

  localparam int unsigned DIV_W = (CLK_DIV_HALF > 1) ? $clog2(CLK_DIV_HALF) : 1;
  localparam int unsigned BIT_W = $clog2(DECIM);
  localparam int unsigned SHIFT = $clog2(256 / DECIM);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             mic_clk_q, mic_clk_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [8:0]       ones_q, ones_d;
  logic             div_last_c, bit_strobe_c, win_last_c;
  logic [8:0]       ones_sum_c, scaled_c;

  // Free-running divider; the strobe marks the last cycle of each high phase.
  always_comb begin
    div_last_c   = (div_cnt_q == DIV_W'(CLK_DIV_HALF - 1));
    div_cnt_d    = div_last_c ? '0 : div_cnt_q + DIV_W'(1);
    mic_clk_d    = div_last_c ? ~mic_clk_q : mic_clk_q;
    bit_strobe_c = div_last_c & mic_clk_q;
  end

  // Window accumulation; the final bit is folded in combinationally so the
  // sample is available on the strobe cycle itself.
  always_comb begin
    ones_d         = ones_q;
    bit_cnt_d      = bit_cnt_q;
    ones_sum_c     = ones_q + 9'(mic_data_i);
    win_last_c     = (bit_cnt_q == BIT_W'(DECIM - 1));
    scaled_c       = ones_sum_c << SHIFT;
    sample_c       = sat_sample(scaled_c);
    sample_valid_c = bit_strobe_c & win_last_c;
    if (clear_i || sample_valid_c) begin
      ones_d    = '0;
      bit_cnt_d = '0;
    end else if (bit_strobe_c) begin
      ones_d    = ones_sum_c;
      bit_cnt_d = bit_cnt_q + BIT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      mic_clk_q <= 1'b0;
      bit_cnt_q <= '0;
      ones_q    <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      mic_clk_q <= mic_clk_d;
      bit_cnt_q <= bit_cnt_d;
      ones_q    <= ones_d;
    end
  end

  assign mic_clk_o = mic_clk_q;

endmodule

// File: rtl/pdm_recorder.sv
// pdm_recorder: records decimated PDM audio into the shared sample memory from
// address 0 upward while record_en is high, stopping when memory is full.
// Ports:
//   CLK, RST            system clock, synchronous active-high reset
//   record_en           record switch (synchronised level)
//   mic_data            PDM data in
//   mic_clk, mic_lrsel  microphone clock and channel select (left)
//   wr_en/wr_addr/wr_data  single-cycle write port to sample memory
//   rec_len             samples in the last completed recording
//   busy, done          high in RECORD / DONE
module pdm_recorder
  import audio_pkg::SAMPLE_W, audio_pkg::rec_state_t,
         audio_pkg::IDLE, audio_pkg::RECORD, audio_pkg::DONE;
#(
  parameter int unsigned CLK_DIV_HALF = 20,
  parameter int unsigned DECIM        = 256,
  parameter int unsigned ADDR_W       = audio_pkg::ADDR_W,
  parameter int unsigned DEPTH        = audio_pkg::DEFAULT_DEPTH
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                record_en,
  input  logic                mic_data,
  output logic                mic_clk,
  output logic                mic_lrsel,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic [ADDR_W-1:0]   rec_len,
  output logic                busy,
  output logic                done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] FULL_LEN  = ADDR_W'(DEPTH);

  rec_state_t          state_q, state_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [SAMPLE_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]   rec_len_q, rec_len_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                clear_c;
  logic [SAMPLE_W-1:0] sample_c;
  logic                sample_valid_c;

  pdm_decimator #(
    .CLK_DIV_HALF(CLK_DIV_HALF),
    .DECIM       (DECIM)
  ) u_decim (
    .clk_i         (CLK),
    .rst_i         (RST),
    .clear_i       (clear_c),
    .mic_data_i    (mic_data),
    .mic_clk_o     (mic_clk),
    .sample_c      (sample_c),
    .sample_valid_c(sample_valid_c)
  );

  // Next state, write port and recording length.
  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rec_len_d = rec_len_q;
    clear_c   = 1'b0;

    // Address advances the cycle after the write it targeted; it parks at the top.
    if (wr_en_q && (wr_addr_q != LAST_ADDR)) begin
      wr_addr_d = wr_addr_q + ADDR_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (record_en) begin
          state_d   = RECORD;
          wr_addr_d = '0;
          rec_len_d = '0;
          clear_c   = 1'b1;
        end
      end
      RECORD: begin
        if (sample_valid_c) begin
          wr_en_d   = 1'b1;
          wr_data_d = sample_c;
          if (wr_addr_q == LAST_ADDR) begin
            state_d   = DONE;
            rec_len_d = FULL_LEN;
          end else if (!record_en) begin
            state_d   = DONE;
            rec_len_d = wr_addr_q + ADDR_W'(1);
          end
        end else if (!record_en) begin
          // A write issuing this cycle has not yet advanced the address.
          state_d   = DONE;
          rec_len_d = wr_addr_q + ADDR_W'(wr_en_q);
        end
      end
      DONE: begin
        if (!record_en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RECORD);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rec_len_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rec_len_q <= rec_len_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign mic_lrsel = 1'b0;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rec_len   = rec_len_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
